// File: rtl/local_mem_pkg.sv
// local_mem_pkg: shared types for the local memory initiator
package local_mem_pkg;
  localparam int ID_W = 4;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} mem_size_t;
  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            err;
  } mem_rsp_t;
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == HALF && off[0]) || (size == WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/local_memory_interface.sv
// local_memory_interface: single-port byte-enabled RAM port with 1-cycle read latency
interface local_memory_interface;
  logic [29:0] addr;
  logic        en;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic [31:0] data_out;
  modport master (output addr, en, be, data_in, input data_out);
  modport slave (input addr, en, be, data_in, output data_out);
endinterface

// File: rtl/local_mem_rsp_fifo.sv
// local_mem_rsp_fifo: synchronous response FIFO with occupancy count
module local_mem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  // pointer and count updates, pointers wrap at DEPTH
  always_comb begin
    do_push = push && cnt_q != CW'(DEPTH);
    do_pop  = pop && cnt_q != '0;
    wr_d    = do_push ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = do_pop ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    dout    = cnt_q != '0 ? mem_q[rd_q] : '0;
    count   = cnt_q;
  end
  // control state, cleared by active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // entry storage, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/local_mem_initiator.sv
// local_mem_initiator: load/store adapter onto a 1-cycle-latency local memory port
module local_mem_initiator #(
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [31:0]           req_wdata,
  input  logic [ID_W-1:0]       req_id,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err,
  local_memory_interface.master mem
);
  import local_mem_pkg::*;
  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int FW = 32 + ID_W + 1;
  logic [1:0]      off, off_q, off_d, size_q, size_d;
  logic            err, accept, pop;
  logic [3:0]      be_full;
  logic [CW:0]     used;
  logic [CW-1:0]   fifo_count;
  logic            s1_valid_q, s1_valid_d, we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     sh, fmt;
  logic [FW-1:0]   push_data, head;
  // request decode: credit check, RAM command and stage 1 capture
  always_comb begin
    used       = {1'b0, fifo_count} + (CW+1)'(s1_valid_q);
    req_ready  = rst && used < (CW+1)'(RSP_DEPTH);
    off        = req_addr[1:0];
    err        = size_err(req_size, off);
    accept     = req_valid && req_ready;
    be_full    = req_size == BYTE ? 4'b0001 << off : req_size == HALF ? 4'b0011 << off : 4'b1111;
    mem.en     = accept && !err;
    mem.be     = accept && !err && req_we ? be_full : 4'b0000;
    mem.addr   = req_addr[31:2];
    mem.data_in = req_size == BYTE ? {4{req_wdata[7:0]}} : req_size == HALF ? {2{req_wdata[15:0]}} : req_wdata;
    s1_valid_d = accept;
    we_d       = accept ? req_we : we_q;
    size_d     = accept ? req_size : size_q;
    sign_d     = accept ? req_sign : sign_q;
    off_d      = accept ? off : off_q;
    id_d       = accept ? req_id : id_q;
    err_d      = accept ? err : err_q;
  end
  // stage 1 register holding the request attributes for the read-data cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      off_q      <= 2'b00;
      id_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      off_q      <= off_d;
      id_q       <= id_d;
      err_q      <= err_d;
    end
  end
  // load formatter: lane-align then zero/sign extend; stores and errors return 0
  always_comb begin
    sh        = mem.data_out >> {off_q, 3'b000};
    fmt       = size_q == BYTE ? {{24{sign_q & sh[7]}}, sh[7:0]} :
                size_q == HALF ? {{16{sign_q & sh[15]}}, sh[15:0]} : sh;
    push_data = {we_q || err_q ? 32'd0 : fmt, id_q, err_q};
    rsp_valid = fifo_count != '0;
    pop       = rsp_valid && rsp_ready;
    {rsp_data, rsp_id, rsp_err} = head;
  end
  local_mem_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid_q),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_local_mem_initiator.sv
// tb_local_mem_initiator: scoreboard bench for local_mem_initiator with a behavioural RAM
module tb_local_mem_initiator;
  logic        clk = 0, rst = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_sign = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic [3:0]  req_id = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_id;
  always #5 clk = ~clk;
  local_memory_interface m();
  local_mem_initiator #(.RSP_DEPTH(4), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_sign(req_sign), .req_wdata(req_wdata), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mem(m)
  );
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (m.en) begin
      for (int i = 0; i < 4; i++) if (m.be[i]) ram[m.addr[9:0]][8*i +: 8] <= m.data_in[8*i +: 8];
      m.data_out <= ram[m.addr[9:0]];
    end
  end
  typedef struct {logic [31:0] data; logic [3:0] id; logic err;} exp_t;
  exp_t        q[$];
  exp_t        head_e;
  logic [31:0] model [1024];
  int          tests = 0, fails = 0, cyc = 0, pops = 0;
  int          acc_cyc[$], pop_cyc[$];
  logic        prev_ok = 0, prev_v = 0, prev_r = 0;
  logic [31:0] prev_d = 0;
  logic [3:0]  prev_id = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] wd, input logic [3:0] id);
    logic [1:0]        off;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       din, v;
    logic signed [7:0] sb;
    logic signed [15:0] sh;
    exp_t              e;
    int                n;
    off = a[1:0];
    err = sz == 2'b11 || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
    be  = 4'b0000;
    din = wd;
    if (sz == 2'b00) begin be[off] = 1'b1; din = {4{wd[7:0]}}; end
    else if (sz == 2'b01) begin be[off] = 1'b1; be[off+1] = 1'b1; din = {2{wd[15:0]}}; end
    else be = 4'b1111;
    v  = model[a[11:2]] >> (8 * off);
    sb = v[7:0];
    sh = v[15:0];
    if (sz == 2'b00) v = sg ? 32'(sb) : {24'd0, v[7:0]};
    else if (sz == 2'b01) v = sg ? 32'(sh) : {16'd0, v[15:0]};
    e.data = (we || err) ? 32'd0 : v;
    e.id   = id;
    e.err  = err;
    q.push_back(e);
    req_addr = a; req_we = we; req_size = sz; req_sign = sg; req_wdata = wd; req_id = id;
    req_valid = 1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      void'(q.pop_back());
      return;
    end
    chk("mem_en", 32'(m.en), 32'(!err));
    chk("mem_be", 32'(m.be), (we && !err) ? 32'(be) : 0);
    chk("mem_addr", 32'(m.addr), 32'(a[31:2]));
    if (we && !err) chk("mem_data_in", m.data_in, din);
    acc_cyc.push_back(cyc);
    @(posedge clk); #1;
    req_valid = 0;
    if (we && !err) for (int i = 0; i < 4; i++) if (be[i]) model[a[11:2]][8*i +: 8] = din[8*i +: 8];
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("drained", q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst && prev_ok && prev_v && !prev_r) begin
      chk("stable_valid", 32'(rsp_valid), 1);
      chk("stable_data", rsp_data, prev_d);
      chk("stable_id", 32'(rsp_id), 32'(prev_id));
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        head_e = q.pop_front();
        chk("rsp_data", rsp_data, head_e.data);
        chk("rsp_id", 32'(rsp_id), 32'(head_e.id));
        chk("rsp_err", 32'(rsp_err), 32'(head_e.err));
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
    prev_ok = rst; prev_v = rsp_valid; prev_r = rsp_ready; prev_d = rsp_data; prev_id = rsp_id;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int base, p0, pc0;
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h1000; req_wdata = 32'h1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mem_en", 32'(m.en), 0);
    chk("rst_mem_be", 32'(m.be), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 1);
    @(posedge clk); #1;
    send(32'h1000, 1, 2'b10, 0, 32'hDEADBEEF, 4'd1);
    drain();
    @(posedge clk); #1;
    send(32'h1003, 0, 2'b00, 1, 0, 4'd2);
    @(negedge clk);
    chk("lat_t1_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_t2_valid", 32'(rsp_valid), 1);
    chk("lat_t2_data", rsp_data, 32'hFFFFFFDE);
    drain();
    @(posedge clk); #1;
    send(32'h2002, 1, 2'b01, 0, 32'h1234, 4'd3);
    send(32'h2002, 0, 2'b01, 0, 0, 4'd4);
    send(32'h1002, 0, 2'b01, 1, 0, 4'd5);
    send(32'h1001, 0, 2'b00, 0, 0, 4'd6);
    send(32'h3001, 0, 2'b10, 0, 0, 4'd7);
    send(32'h2001, 0, 2'b01, 1, 0, 4'd8);
    send(32'h1000, 1, 2'b11, 0, 32'h55, 4'd9);
    drain();
    @(posedge clk); #1;
    rsp_ready = 0;
    base = acc_cyc.size();
    fork
      for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i % 4), 0, 2'b00, i[0], 0, 4'(i));
      begin
        repeat (10) @(negedge clk);
        chk("bp_ready_low", 32'(req_ready), 0);
        chk("bp_accepted", acc_cyc.size() - base, 4);
        @(posedge clk); #1;
        rsp_ready = 1;
      end
    join
    drain();
    @(posedge clk); #1;
    base = acc_cyc.size();
    p0 = pops;
    pc0 = pop_cyc.size();
    send(32'h5000, 1, 2'b10, 0, 32'h89ABCDEF, 4'd1);
    send(32'h5002, 0, 2'b00, 1, 0, 4'd2);
    send(32'h5002, 0, 2'b01, 0, 0, 4'd3);
    send(32'h5001, 1, 2'b00, 0, 32'h7E, 4'd4);
    send(32'h5000, 0, 2'b10, 0, 0, 4'd5);
    send(32'h5000, 0, 2'b01, 1, 0, 4'd6);
    send(32'h5003, 0, 2'b00, 1, 0, 4'd7);
    send(32'h5000, 0, 2'b00, 0, 0, 4'd8);
    drain();
    chk("stream_acc_span", acc_cyc[base+7] - acc_cyc[base], 7);
    chk("stream_pops", pops - p0, 8);
    chk("stream_pop_span", pop_cyc[pc0+7] - pop_cyc[pc0], 7);
    @(posedge clk); #1;
    rsp_ready = 0;
    send(32'h4000, 1, 2'b10, 0, 32'hCAFEF00D, 4'd10);
    send(32'h1000, 0, 2'b10, 0, 0, 4'd11);
    send(32'h1004, 0, 2'b00, 0, 0, 4'd12);
    rst = 0;
    q.delete();
    @(posedge clk); #1;
    rst = 1;
    rsp_ready = 1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    send(32'h4000, 0, 2'b10, 0, 0, 4'd13);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/local_mem_initiator.md
# local_mem_initiator

Master-side adapter driving a `local_memory_interface` port of the on-chip local memory, with a single-port byte-enabled RAM behind it and a 1-cycle read latency. It accepts byte, halfword and word load/store requests over a valid/ready handshake. It generates word address, byte enables and lane-replicated write data, and aligns and extends read data. Responses are returned in order through a backpressured response FIFO. It sits between a load/store unit (or DMA/debug requester) and one `local_mem` port.

## Interface
- `RSP_DEPTH`, 4: response FIFO entries; minimum 2; 4 sustains one request per cycle.
- `ID_W`, 4: request tag width.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1 = store.
- `req_size` in 2: `mem_size_t` (BYTE/HALF/WORD).
- `req_sign` in 1: sign-extend loads.
- `req_wdata` in 32: store data, right-aligned.
- `req_id` in ID_W: tag returned with the response.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 32: load result; 0 for stores and errors.
- `rsp_id` out ID_W: tag of the request.
- `rsp_err` out 1: misaligned or reserved size.
- `mem` `local_memory_interface.master`: `addr` = `req_addr[31:2]`, `en`, `be[3:0]`, `data_in[31:0]` (write data), `data_out[31:0]` (RAM read data).

## Operation
- Accept on `req_valid && req_ready`. `req_ready = rst && (fifo_count + s1_valid < RSP_DEPTH)`. This signal is combinational from registered state only, with no path from `rsp_ready`.
- **Accept cycle T:** `mem.en = accept && !err`; `mem.addr`, `be` and `data_in` are combinational from the request. `be` is gated to 0 when `req_we = 0` (loads read the full word).
- **Enables:** BYTE `be = 4'b0001 << off`; HALF `4'b0011 << off`; WORD `4'b1111`. Here `off = req_addr[1:0]`.
- **Write data:** BYTE `{4{wdata[7:0]}}`; HALF `{2{wdata[15:0]}}`; WORD `wdata`.
- **Errors:** HALF with `off[0] = 1`, WORD with `off != 0`, or size `2'b11` → err. No RAM access (`mem.en = 0`), but the request still produces a response.
- **Stage 1 register**, loaded at accept: `s1_valid`, `we`, `size`, `sign`, `off`, `id`, `err`.
- **T+1:** format `mem.data_out >> (8*off)`. Zero-extend or sign-extend from bit 7 (BYTE) or bit 15 (HALF). Stores and errors produce `rsp_data = 0`. Push `{data, id, err}` into the FIFO; the push always has space by the credit rule.
- **Responses:** FIFO head drives `rsp_*`; pop on `rsp_valid && rsp_ready`. Responses are strictly in request order.

## Timing
- **Latency:** accept at T → `rsp_valid` at T+2 at the earliest. Throughput is 1 request per cycle when `rsp_ready = 1` and `RSP_DEPTH >= 4`.
- **Reset values:** while `rst = 0`: `req_ready = 0`, `mem.en = 0`, `mem.be = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_id = 0`, `rsp_err = 0`, `s1_valid = 0`, FIFO empty.
- **Reset mid-operation:** in-flight and queued responses are discarded. Stores already issued to the RAM remain committed. `req_ready` returns to 1 on the first cycle after `rst = 1`.
- **FIFO full:** `req_ready = 0` until a pop frees a credit; a request stalled this way gets no `mem.en`.
- **Push and pop in the same cycle:** count unchanged; the pointers wrap modulo `RSP_DEPTH`.
- **Stability:** `rsp_*` holds stable while `rsp_valid && !rsp_ready`. Requests must stay stable while `req_valid && !req_ready`.

## Structure
- `local_mem_pkg`:
  - `typedef enum logic [1:0] mem_size_t {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10}`; `2'b11` is reserved.
  - Response struct `{data[31:0], id, err}`, parameterised via the `ID_W` localparam default.
- Sub-module `local_mem_rsp_fifo`: synchronous FIFO with `DEPTH` entries of width `32 + ID_W + 1`, count output, and the same `rst` semantics.
- Top level holds the request decode, stage 1 register and load formatter.

## Test plan
- **Store then load:** store WORD `0x1000 = 0xDEADBEEF` → `be = 1111`, `data_in = 0xDEADBEEF`, response err 0. Then load BYTE signed `0x1003` → `rsp_data = 0xFFFFFFDE` at T+2.
- **Halfword store and load:** store HALF `0x2002 = 0x1234` → `be = 1100`, `data_in = 0x12341234`. Load HALF unsigned `0x2002` → `0x00001234`.
- **Misaligned:** load WORD `0x3001` → `mem.en` never asserted; response `err = 1`, `data = 0`, correct id.
- **Backpressure:** 8 back-to-back loads with ids 0–7 and `rsp_ready = 0` → `req_ready` drops after 4 accepted. With `rsp_ready = 1`, responses return ids 0–7 in order with no loss or duplication.
- **Streaming:** continuous requests with `rsp_ready = 1` → one accept per cycle, one response per cycle.
- **Mid-burst reset:** assert `rst = 0` for one cycle with 3 responses outstanding → no `rsp_valid` afterwards. `req_ready = 1` on the next cycle, and a store issued before reset is readable.
